alu_share_sched: RTL and testbench
==================================

Name: alu_share_sched

Overview:
- Round-robin scheduler that shares one external single-function-per-opcode ALU (the and/or/xor/add slices) among NUM_REQ requesters.
- Accepts one operation at a time over a valid/ready handshake and drives the shared ALU operand/opcode lines.
- Waits a fixed ALU_LAT cycles, captures the result and returns it to the requester that issued the operation.
- Sits between the requesting engines and the shared alu datapath; it does not interpret opcodes.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width in bits
- OPW, 3, opcode width
- ALU_LAT, 1, cycles from operands stable on alu_a/alu_b/alu_op to alu_res valid (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester operation valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- req_a  in  NUM_REQ*WIDTH  packed operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  packed operand B, same packing
- req_op  in  NUM_REQ*OPW  packed opcode, requester i at [i*OPW +: OPW]
- alu_a  out  WIDTH  shared ALU operand A
- alu_b  out  WIDTH  shared ALU operand B
- alu_op  out  OPW  shared ALU opcode
- alu_res  in  WIDTH  shared ALU result
- rsp_valid  out  NUM_REQ  one-hot result valid to the owning requester
- rsp_data  out  WIDTH  result data, shared by all requesters
- rsp_ready  in  NUM_REQ  per-requester result accept
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, rr_ptr=0, grant register=0.
  - alu_a/alu_b/alu_op/rsp_data = 0; rsp_valid = 0; req_ready = 0; busy = 0.
  - Reset mid-operation silently drops the in-flight operation; no response is produced after reset.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Round-robin pick: first i with req_valid[i]=1, searching from rr_ptr upward with wrap modulo NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle for the winner g only. The handshake completes that cycle.
  - On the clock edge: latch req_a/req_b/req_op of g into alu_a/alu_b/alu_op registers; latch g; lat_cnt=ALU_LAT-1; go EXEC.
  - No req_valid: stay IDLE, all req_ready=0.
- EXEC:
  - alu_a/alu_b/alu_op held constant; req_ready=0.
  - When lat_cnt==0: rsp_data<=alu_res; go RESP. Otherwise lat_cnt decrements.
  - EXEC therefore lasts exactly ALU_LAT cycles.
- RESP:
  - rsp_valid[g]=1 (registered, one-hot); rsp_data stable.
  - On rsp_ready[g]=1: rsp_valid clears next edge, rr_ptr<=(g+1) mod NUM_REQ, go IDLE.
  - rsp_ready bits other than g are ignored.
  - Stalls indefinitely until the owner accepts; no new request is accepted during the stall.
- alu_a/alu_b/alu_op keep their last values outside EXEC. They are not cleared on return to IDLE.
- rsp_data holds its last value after the handshake.
- Latency: accept edge to rsp_valid high = ALU_LAT+1 cycles. Minimum issue interval = ALU_LAT+2 cycles with rsp_ready tied high.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 other operations.
- rr_ptr advances only on response completion, never on a bare grant.
- Requester deasserting req_valid without a handshake: allowed, no effect.
- req_valid from the current owner while in EXEC/RESP: ignored until IDLE.

Test Plan:
- Reset check: assert rst_n=0 mid-EXEC (ALU_LAT=3) -> busy, rsp_valid, req_ready all 0 immediately (async); after release, no response for the dropped op.
- Single op: requester 2 sends a=8'h3C, b=8'h0F, op=3'd1; model ALU returns a|b after ALU_LAT=1 -> req_ready=4'b0100 in the same cycle; rsp_valid=4'b0100 with rsp_data=8'h3F two edges later.
- Round-robin: all four req_valid held high, rsp_ready tied high -> grant order 0,1,2,3,0; each issue spaced ALU_LAT+2 cycles.
- Pointer wrap: rr_ptr=3, requesters 0 and 3 valid -> 3 is served first, then 0; rr_ptr returns to 1.
- Back-pressure: rsp_ready[1]=0 for 5 cycles with another requester valid -> rsp_valid/rsp_data stable, no req_ready asserted; the new grant appears in the first IDLE cycle after rsp_ready[1]=1.
- Latency sweep: ALU_LAT=1,2,4 with alu_res=a+b, a=8'hFF, b=8'h01 -> rsp_data=8'h00 (wrap) and rsp_valid at accept+ALU_LAT+1 cycles for each setting.

Source files
------------

// File: rtl/alu_share_sched.sv
// Round-robin scheduler sharing one fixed-latency ALU among NUM_REQ requesters.
// One operation in flight: accept, wait ALU_LAT cycles, return result to owner.
module alu_share_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned OPW     = 3,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*OPW-1:0]   req_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [OPW-1:0]           alu_op,
  input  logic [WIDTH-1:0]         alu_res,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic                     busy
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [IdxW:0] NumReqW = (IdxW + 1)'(NUM_REQ);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]     grant_q, grant_d;
  logic [CntW-1:0]     lat_cnt_q, lat_cnt_d;
  logic [WIDTH-1:0]    alu_a_q, alu_a_d;
  logic [WIDTH-1:0]    alu_b_q, alu_b_d;
  logic [OPW-1:0]      alu_op_q, alu_op_d;
  logic [WIDTH-1:0]    rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;

  logic [WIDTH-1:0]    a_arr  [NUM_REQ];
  logic [WIDTH-1:0]    b_arr  [NUM_REQ];
  logic [OPW-1:0]      op_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i]  = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i]  = req_b[i*WIDTH +: WIDTH];
    assign op_arr[i] = req_op[i*OPW +: OPW];
  end

  // Round-robin search starting at rr_ptr_q, wrapping modulo NUM_REQ.
  logic            found;
  logic [IdxW-1:0] win;
  logic [IdxW:0]   cand;

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IdxW + 1)'(k);
      if (cand >= NumReqW) begin
        cand = cand - NumReqW;
      end
      if (!found && req_valid[cand[IdxW-1:0]]) begin
        found = 1'b1;
        win   = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    lat_cnt_d   = lat_cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    req_ready   = '0;
    unique case (state_q)
      StIdle: begin
        // Gated by rst_n so no handshake is offered while reset is held.
        if (found && rst_n) begin
          req_ready[win] = 1'b1;
          alu_a_d        = a_arr[win];
          alu_b_d        = b_arr[win];
          alu_op_d       = op_arr[win];
          grant_d        = win;
          lat_cnt_d      = CntW'(ALU_LAT - 1);
          state_d        = StExec;
        end
      end
      StExec: begin
        if (lat_cnt_q == '0) begin
          rsp_data_d           = alu_res;
          rsp_valid_d          = '0;
          rsp_valid_d[grant_q] = 1'b1;
          state_d              = StResp;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready[grant_q]) begin
          rsp_valid_d = '0;
          rr_ptr_d    = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      lat_cnt_q   <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      lat_cnt_q   <= lat_cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_sched.sv
// Scoreboard bench: four scheduler instances (ALU_LAT 1..4), each with a latency-honest
// ALU model, grant/response monitors and directed stimulus.
module tb_alu_share_sched;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int OW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_done = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] alu_f(input logic [OW-1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return a + b;
      default: return '0;
    endcase
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_lat
    localparam int LAT = gi + 1;

    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*W-1:0]  req_a, req_b;
    logic [N*OW-1:0] req_op;
    logic [W-1:0]    alu_a, alu_b, alu_res, rsp_data;
    logic [OW-1:0]   alu_op;
    logic            busy;

    int           exp_g[$];
    int           exp_rg[$];
    logic [W-1:0] exp_rd[$];
    int           last_acc = -1;
    bit           chk_space = 1'b0;
    bit           rsp_seen = 1'b0;
    int           age = 1000;
    int           gexp;
    logic [W-1:0] dexp;

    alu_share_sched #(
      .NUM_REQ(N),
      .WIDTH  (W),
      .OPW    (OW),
      .ALU_LAT(LAT)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_a    (req_a),
      .req_b    (req_b),
      .req_op   (req_op),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_op   (alu_op),
      .alu_res  (alu_res),
      .rsp_valid(rsp_valid),
      .rsp_data (rsp_data),
      .rsp_ready(rsp_ready),
      .busy     (busy)
    );

    // Result is only correct once operands have been stable for LAT cycles.
    always @(posedge clk) begin
      if (req_ready != '0) age <= 1;
      else if (age < 1000) age <= age + 1;
    end
    assign alu_res = (age >= LAT) ? alu_f(alu_op, alu_a, alu_b) : ~alu_f(alu_op, alu_a, alu_b);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      check($sformatf("lat%0d_%s", LAT, nm), act, exp);
    endtask

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    task automatic put(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [OW-1:0] op);
      req_a[i*W +: W]    = a;
      req_b[i*W +: W]    = b;
      req_op[i*OW +: OW] = op;
    endtask

    task automatic expect_op(input int g, input logic [W-1:0] d);
      exp_g.push_back(g);
      exp_rg.push_back(g);
      exp_rd.push_back(d);
    endtask

    task automatic wait_grants();
      for (int t = 0; t < 100 && exp_g.size() != 0; t++) begin
        @(negedge clk);
        #1;
      end
      if (exp_g.size() != 0) begin
        chk("grant_timeout", exp_g.size(), 0);
        exp_g.delete();
      end
      step();
    endtask

    task automatic drain();
      for (int t = 0; t < 100 && (exp_rg.size() != 0 || busy); t++) step();
      if (exp_rg.size() != 0) begin
        chk("rsp_timeout", exp_rg.size(), 0);
        exp_rg.delete();
        exp_rd.delete();
      end
    endtask

    // Grant monitor.
    always @(negedge clk) begin
      if (rst_n && req_ready != '0) begin
        if (exp_g.size() == 0) chk("unexpected_grant", req_ready, 0);
        else begin
          gexp = exp_g.pop_front();
          chk("grant", req_ready, 32'(1) << gexp);
        end
        if (chk_space && last_acc >= 0) chk("issue_spacing", cyc - last_acc, LAT + 2);
        last_acc = cyc;
      end
    end

    // Response monitor.
    always @(negedge clk) begin
      if (!rst_n) rsp_seen = 1'b0;
      else begin
        if (rsp_valid != '0 && !rsp_seen) chk("rsp_latency", cyc - last_acc, LAT + 1);
        rsp_seen = (rsp_valid != '0);
        if ((rsp_valid & rsp_ready) != '0) begin
          if (exp_rg.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
          else begin
            gexp = exp_rg.pop_front();
            dexp = exp_rd.pop_front();
            chk("rsp_owner", rsp_valid, 32'(1) << gexp);
            chk("rsp_data", rsp_data, dexp);
          end
        end
      end
    end

    if (gi == 0) begin : g_main
      initial begin
        rst_n = 1'b1; req_valid = '1; rsp_ready = '1;
        req_a = '0; req_b = '0; req_op = '0;
        #2 rst_n = 1'b0;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu", {alu_a, alu_b, alu_op}, 0);
        chk("rst_rsp_data", rsp_data, 0);

        // Round robin from reset pointer 0 with every requester asking.
        put(0, 8'hF0, 8'h3C, 3'd0); put(1, 8'hA5, 8'h0F, 3'd1);
        put(2, 8'hA5, 8'hFF, 3'd2); put(3, 8'h7F, 8'h01, 3'd3);
        expect_op(0, 8'h30); expect_op(1, 8'hAF); expect_op(2, 8'h5A);
        expect_op(3, 8'h80); expect_op(0, 8'h30);
        last_acc = -1; chk_space = 1'b1;
        rst_n = 1'b1;
        wait_grants();
        req_valid = '0; chk_space = 1'b0;
        drain();

        // Single op from requester 2.
        put(2, 8'h3C, 8'h0F, 3'd1);
        expect_op(2, 8'h3F);
        req_valid = 4'b0100;
        wait_grants();
        req_valid = '0;
        drain();

        // Pointer now 3: requester 3 beats 0, then pointer wraps to 1.
        put(3, 8'h12, 8'h34, 3'd3); put(0, 8'hC3, 8'h3C, 3'd2);
        expect_op(3, 8'h46); expect_op(0, 8'hFF);
        req_valid = 4'b1001;
        wait_grants();
        req_valid = '0;
        drain();

        // Pointer 1 picks requester 1 over 0; owner stalls the response.
        put(1, 8'h5A, 8'h0F, 3'd0); put(0, 8'h80, 8'h80, 3'd3);
        rsp_ready = 4'b1101;
        expect_op(1, 8'h0A);
        req_valid = 4'b0011;
        wait_grants();
        req_valid = 4'b0001;
        for (int t = 0; t < 20 && rsp_valid == '0; t++) step();
        repeat (5) begin
          @(negedge clk);
          chk("bp_rsp_valid", rsp_valid, 4'b0010);
          chk("bp_rsp_data", rsp_data, 8'h0A);
          chk("bp_req_ready", req_ready, 0);
        end
        expect_op(0, 8'h00);
        @(posedge clk);
        #1 rsp_ready = 4'b1111;
        step();
        #1 chk("bp_regrant", req_ready, 4'b0001);
        wait_grants();
        req_valid = '0;
        drain();
        n_done++;
      end
    end else begin : g_aux
      initial begin
        rst_n = 1'b1; req_valid = '0; rsp_ready = '1;
        req_a = '0; req_b = '0; req_op = '0;
        #2 rst_n = 1'b0;
        step(); step();
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Latency sweep with wrapping add.
        put(1, 8'hFF, 8'h01, 3'd3);
        expect_op(1, 8'h00);
        req_valid = 4'b0010;
        wait_grants();
        req_valid = '0;
        drain();

        // Async reset during EXEC drops the operation.
        put(2, 8'h10, 8'h20, 3'd3);
        exp_g.push_back(2);
        req_valid = 4'b0100;
        wait_grants();
        chk("exec_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_req_ready", req_ready, 0);
        step();
        req_valid = '0;
        step();
        rst_n = 1'b1;
        repeat (LAT + 4) begin
          @(negedge clk);
          chk("no_rsp_after_rst", rsp_valid, 0);
        end
        n_done++;
      end
    end
  end

  initial begin
    for (int t = 0; t < 5000 && n_done < 4; t++) @(posedge clk);
    if (n_done < 4) check("global_timeout", n_done, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
